// File: rtl/bomberman_key_decoder.sv
// bomberman_key_decoder: turns the raw two-slot USB keycode word into
// per-player, frame-aligned move and bomb commands.
//
// Ports:
//   Clk, Reset_n             system clock, async active-low reset
//   Frame_Clk                VGA_VS, asynchronous to Clk
//   Keycode[15:0]            slot 1 in [15:8], slot 0 in [7:0], 0x00 = empty
//   Game_Enable              high while the game is in play
//   Frame_Tick               one-cycle pulse per VS falling edge
//   Move_Valid_x, Dir_x      move pulse and direction (00 dn, 01 up, 10 lt, 11 rt)
//   Bomb_Req_x               bomb pulse, once per press
module bomberman_key_decoder #(
    parameter int unsigned MOVE_PERIOD = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Frame_Clk,
    input  logic [15:0] Keycode,
    input  logic        Game_Enable,
    output logic        Frame_Tick,
    output logic        Move_Valid_1,
    output logic        Move_Valid_2,
    output logic [1:0]  Dir_1,
    output logic [1:0]  Dir_2,
    output logic        Bomb_Req_1,
    output logic        Bomb_Req_2
);

    localparam logic [3:0] RELOAD = 4'(MOVE_PERIOD - 1);

    typedef enum logic {IDLE, HELD} state_t;

    // Per-slot decode result packed as {dir_valid, dir[1:0], bomb}
    function automatic logic [3:0] dec(input logic [7:0] c, input logic p);
        logic [3:0] r;
        r = 4'b0000;
        if (!p) begin
            case (c)
                8'h1A:   r = {1'b1, 2'b01, 1'b0};
                8'h16:   r = {1'b1, 2'b00, 1'b0};
                8'h04:   r = {1'b1, 2'b10, 1'b0};
                8'h07:   r = {1'b1, 2'b11, 1'b0};
                8'h2C:   r = {1'b0, 2'b00, 1'b1};
                default: r = 4'b0000;
            endcase
        end else begin
            case (c)
                8'h52:   r = {1'b1, 2'b01, 1'b0};
                8'h51:   r = {1'b1, 2'b00, 1'b0};
                8'h50:   r = {1'b1, 2'b10, 1'b0};
                8'h4F:   r = {1'b1, 2'b11, 1'b0};
                8'h28:   r = {1'b0, 2'b00, 1'b1};
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    logic        r_vs_s1;
    logic        r_vs_s2;
    logic        r_vs_d;
    logic        r_tick;
    logic [15:0] r_kc_q;

    state_t          r_state [2];
    logic [1:0][3:0] r_cnt;
    logic [1:0]      r_bprev;
    logic [1:0]      r_move;
    logic [1:0]      r_bomb;
    logic [1:0][1:0] r_dir;

    logic [1:0][3:0] w_slot0;
    logic [1:0][3:0] w_slot1;
    logic [1:0]      w_dv;
    logic [1:0][1:0] w_dh;
    logic [1:0]      w_bh;

    state_t          w_state_nx [2];
    logic [1:0][3:0] w_cnt_nx;
    logic [1:0]      w_bprev_nx;
    logic [1:0]      w_move_nx;
    logic [1:0]      w_bomb_nx;
    logic [1:0][1:0] w_dir_nx;

    // Sync flops idle high so release never looks like a VS fall
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_s1 <= 1'b1;
            r_vs_s2 <= 1'b1;
            r_vs_d  <= 1'b1;
            r_tick  <= 1'b0;
            r_kc_q  <= 16'h0000;
        end else begin
            r_vs_s1 <= Frame_Clk;
            r_vs_s2 <= r_vs_s1;
            r_vs_d  <= r_vs_s2;
            r_tick  <= r_vs_d & ~r_vs_s2;
            r_kc_q  <= Keycode;
        end
    end

    // Slot 0 takes priority when both slots hold a direction
    always_comb begin
        w_slot0 = '0;
        w_slot1 = '0;
        w_dv    = '0;
        w_dh    = '0;
        w_bh    = '0;
        for (int p = 0; p < 2; p++) begin
            w_slot0[p] = dec(r_kc_q[7:0], 1'(p));
            w_slot1[p] = dec(r_kc_q[15:8], 1'(p));
            w_dv[p]    = w_slot0[p][3] | w_slot1[p][3];
            w_dh[p]    = w_slot0[p][3] ? w_slot0[p][2:1] : w_slot1[p][2:1];
            w_bh[p]    = w_slot0[p][0] | w_slot1[p][0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= IDLE;
            end
            r_cnt   <= '0;
            r_bprev <= 2'b11;
            r_move  <= 2'b00;
            r_bomb  <= 2'b00;
            r_dir   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= w_state_nx[p];
            end
            r_cnt   <= w_cnt_nx;
            r_bprev <= w_bprev_nx;
            r_move  <= w_move_nx;
            r_bomb  <= w_bomb_nx;
            r_dir   <= w_dir_nx;
        end
    end

    // While HELD, r_dir is the direction being held
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_state_nx[p] = r_state[p];
        end
        w_cnt_nx   = r_cnt;
        w_bprev_nx = r_bprev;
        for (int p = 0; p < 2; p++) begin
            if (!Game_Enable) begin
                w_state_nx[p] = IDLE;
                w_cnt_nx[p]   = 4'd0;
                w_bprev_nx[p] = 1'b1;
            end else if (r_tick) begin
                w_bprev_nx[p] = w_bh[p];
                case (r_state[p])
                    IDLE: begin
                        if (w_dv[p]) begin
                            w_state_nx[p] = HELD;
                            w_cnt_nx[p]   = RELOAD;
                        end
                    end
                    HELD: begin
                        if (!w_dv[p]) begin
                            w_state_nx[p] = IDLE;
                        end else if (w_dh[p] != r_dir[p]) begin
                            w_cnt_nx[p] = RELOAD;
                        end else if (r_cnt[p] == 4'd0) begin
                            w_cnt_nx[p] = RELOAD;
                        end else begin
                            w_cnt_nx[p] = r_cnt[p] - 4'd1;
                        end
                    end
                    default: w_state_nx[p] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_move_nx = 2'b00;
        w_bomb_nx = 2'b00;
        w_dir_nx  = r_dir;
        for (int p = 0; p < 2; p++) begin
            if (Game_Enable && r_tick) begin
                w_bomb_nx[p] = w_bh[p] & ~r_bprev[p];
                if (w_dv[p]) begin
                    if (r_state[p] == IDLE || w_dh[p] != r_dir[p]
                        || r_cnt[p] == 4'd0) begin
                        w_move_nx[p] = 1'b1;
                        w_dir_nx[p]  = w_dh[p];
                    end
                end
            end
        end
    end

    assign Frame_Tick   = r_tick;
    assign Move_Valid_1 = r_move[0];
    assign Move_Valid_2 = r_move[1];
    assign Dir_1        = r_dir[0];
    assign Dir_2        = r_dir[1];
    assign Bomb_Req_1   = r_bomb[0];
    assign Bomb_Req_2   = r_bomb[1];

endmodule

// File: tb/tb_bomberman_key_decoder.sv
// tb_bomberman_key_decoder: directed frame table plus randomized frames
// checked against a run-length reference model.
module tb_bomberman_key_decoder;

    localparam int MP = 4;

    logic        Clk;
    logic        Reset_n;
    logic        Frame_Clk;
    logic [15:0] Keycode;
    logic        Game_Enable;
    logic        Frame_Tick;
    logic        Move_Valid_1;
    logic        Move_Valid_2;
    logic [1:0]  Dir_1;
    logic [1:0]  Dir_2;
    logic        Bomb_Req_1;
    logic        Bomb_Req_2;

    int checks;
    int failures;

    bomberman_key_decoder #(.MOVE_PERIOD(MP)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Frame_Clk    (Frame_Clk),
        .Keycode      (Keycode),
        .Game_Enable  (Game_Enable),
        .Frame_Tick   (Frame_Tick),
        .Move_Valid_1 (Move_Valid_1),
        .Move_Valid_2 (Move_Valid_2),
        .Dir_1        (Dir_1),
        .Dir_2        (Dir_2),
        .Bomb_Req_1   (Bomb_Req_1),
        .Bomb_Req_2   (Bomb_Req_2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] kc;
        logic        en;
        logic        mv1;
        logic [1:0]  d1;
        logic        b1;
        logic        mv2;
        logic [1:0]  d2;
        logic        b2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [15:0] kc, input logic en,
        input logic mv1, input logic [1:0] d1, input logic b1,
        input logic mv2, input logic [1:0] d2, input logic b2);
        vec_t v;
        v.kc = kc; v.en = en;
        v.mv1 = mv1; v.d1 = d1; v.b1 = b1;
        v.mv2 = mv2; v.d2 = d2; v.b2 = b2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // One frame: settle keys, drop VS, watch six cycles, raise VS.
    // Tick is expected on the 3rd edge, commands on the 4th.
    task automatic run_frame(input vec_t v, input string tag,
                             input bit rst_mid);
        logic [5:0] tp, m1, m2, b1, b2;
        logic [1:0] g1, g2;
        tp = '0; m1 = '0; m2 = '0; b1 = '0; b2 = '0;
        g1 = '0; g2 = '0;
        @(negedge Clk);
        Keycode = v.kc;
        Game_Enable = v.en;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Frame_Clk = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk);
            #1;
            tp[c] = Frame_Tick;
            m1[c] = Move_Valid_1;
            m2[c] = Move_Valid_2;
            b1[c] = Bomb_Req_1;
            b2[c] = Bomb_Req_2;
            if (c == 3) begin
                g1 = Dir_1;
                g2 = Dir_2;
                if (rst_mid) begin
                    Frame_Clk = 1'b1;
                    Reset_n = 1'b0;
                    #1;
                    chk({tag, " rst_mv1"}, 8'(Move_Valid_1), 8'h0);
                    chk({tag, " rst_dir1"}, 8'(Dir_1), 8'h0);
                    chk({tag, " rst_tick"}, 8'(Frame_Tick), 8'h0);
                end
            end
        end
        chk({tag, " tick"}, 8'(tp), 8'h04);
        chk({tag, " mv1"}, 8'(m1), v.mv1 ? 8'h08 : 8'h00);
        chk({tag, " mv2"}, 8'(m2), v.mv2 ? 8'h08 : 8'h00);
        chk({tag, " bomb1"}, 8'(b1), v.b1 ? 8'h08 : 8'h00);
        chk({tag, " bomb2"}, 8'(b2), v.b2 ? 8'h08 : 8'h00);
        if (v.mv1) chk({tag, " dir1"}, 8'(g1), 8'(v.d1));
        if (v.mv2) chk({tag, " dir2"}, 8'(g2), 8'(v.d2));
        @(negedge Clk);
        Frame_Clk = 1'b1;
        repeat (4) @(posedge Clk);
    endtask

    // Reference model: a held direction fires on the 1st, (MP+1)th, ...
    // consecutive enabled tick it is seen; bomb fires on a 0->1 of the
    // held flag between enabled ticks (flag forced to 1 while disabled).
    int         m_run [2];
    logic [1:0] m_last [2];
    logic       m_bprev [2];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_run[p] = 0;
            m_last[p] = 2'b00;
            m_bprev[p] = 1'b1;
        end
    endtask

    task automatic key_of(input logic [7:0] c, input int p,
                          output logic v, output logic [1:0] d,
                          output logic b);
        logic [7:0] up, dn, lt, rt, bm;
        up = p == 0 ? 8'h1A : 8'h52;
        dn = p == 0 ? 8'h16 : 8'h51;
        lt = p == 0 ? 8'h04 : 8'h50;
        rt = p == 0 ? 8'h07 : 8'h4F;
        bm = p == 0 ? 8'h2C : 8'h28;
        v = 1'b1; d = 2'b00; b = 1'b0;
        if (c == up) d = 2'b01;
        else if (c == dn) d = 2'b00;
        else if (c == lt) d = 2'b10;
        else if (c == rt) d = 2'b11;
        else v = 1'b0;
        b = (c == bm);
    endtask

    task automatic model_frame(input logic [15:0] kc, input logic en,
                               output vec_t e);
        logic       v0, v1, b0, b1, hv, hb, mv, bb;
        logic [1:0] d0, d1, hd;
        e = mk(kc, en, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            key_of(kc[7:0], p, v0, d0, b0);
            key_of(kc[15:8], p, v1, d1, b1);
            hv = v0 | v1;
            hd = v0 ? d0 : d1;
            hb = b0 | b1;
            mv = 1'b0;
            bb = 1'b0;
            if (!en) begin
                m_run[p] = 0;
                m_bprev[p] = 1'b1;
            end else begin
                bb = hb && !m_bprev[p];
                m_bprev[p] = hb;
                if (hv) begin
                    if (m_run[p] > 0 && hd == m_last[p]) m_run[p]++;
                    else m_run[p] = 1;
                    m_last[p] = hd;
                    mv = ((m_run[p] - 1) % MP) == 0;
                end else begin
                    m_run[p] = 0;
                end
            end
            if (p == 0) begin
                e.mv1 = mv; e.d1 = hd; e.b1 = bb;
            end else begin
                e.mv2 = mv; e.d2 = hd; e.b2 = bb;
            end
        end
    endtask

    logic [7:0] pool [12];

    initial begin
        vec_t e;
        logic [15:0] kc;
        logic en;
        int tcnt;
        checks = 0;
        failures = 0;
        Reset_n = 1'b0;
        Frame_Clk = 1'b1;
        Keycode = 16'h0000;
        Game_Enable = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset outs", {Frame_Tick, Move_Valid_1, Move_Valid_2,
            Bomb_Req_1, Bomb_Req_2, Dir_1, 1'b0}, 8'h00);
        chk("reset dir2", 8'(Dir_2), 8'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_frame(mk(16'h0000, 1, 0, 0, 0, 0, 0, 0), "idle", 0);
        chk("idle dir1", 8'(Dir_1), 8'h0);
        chk("idle dir2", 8'(Dir_2), 8'h0);

        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(16'h001A, 1, (i == 1 || i == 5 || i == 9),
                             2'b01, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0007, 1, 1, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0007, 1, 0, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0004, 1, 1, 2'b10, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 6; i++)
            tbl.push_back(mk(16'h2C52, 1, 0, 0, (i == 1),
                             (i == 1 || i == 5), 2'b01, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(16'h0428, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0428, 1, 1, 2'b10, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0428, 1, 0, 2'b10, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0028, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(16'h1A16, 1, 1, 2'b00, 0, 0, 0, 0));

        foreach (tbl[i])
            run_frame(tbl[i], $sformatf("tbl%0d", i), 0);

        // Direction change fires, then reset lands right after the pulse
        run_frame(mk(16'h0007, 1, 1, 2'b11, 0, 0, 0, 0), "midrst", 1);
        @(negedge Clk);
        Reset_n = 1'b1;
        tcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk);
            #1;
            if (Frame_Tick) tcnt++;
        end
        chk("no tick after release", 8'(tcnt), 8'h0);
        model_reset();

        pool[0] = 8'h00; pool[1] = 8'h1A; pool[2] = 8'h16;
        pool[3] = 8'h04; pool[4] = 8'h07; pool[5] = 8'h2C;
        pool[6] = 8'h52; pool[7] = 8'h51; pool[8] = 8'h50;
        pool[9] = 8'h4F; pool[10] = 8'h28; pool[11] = 8'h33;
        kc = 16'h0007;
        en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                kc[7:0]  = pool[$urandom_range(0, 11)];
                kc[15:8] = pool[$urandom_range(0, 11)];
            end
            en = ($urandom_range(0, 9) != 0);
            model_frame(kc, en, e);
            run_frame(e, $sformatf("rnd%0d", i), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bomberman_key_decoder.md
# bomberman_key_decoder

Input stage between the NIOS keycode PIO and `Game_Hub`. It turns the raw 16-bit USB keycode word into per-player commands, one per video frame:
- a move pulse with a direction, repeated at a fixed rate while the key is held;
- a bomb-request pulse, once per press.

All commands are aligned to a frame tick derived from `VGA_VS`, so game logic updates exactly once per frame.

## Interface
Parameters:
- `MOVE_PERIOD`, 4: frames between repeated moves while a direction key stays held (legal 1–15).

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Frame_Clk` in 1: `VGA_VS` from the VGA controller. Asynchronous to `Clk`; synchronised internally.
- `Keycode` in 16: two USB HID key slots, `[7:0]` = slot 0, `[15:8]` = slot 1. Synchronous to `Clk`; 0x00 = empty.
- `Game_Enable` in 1: high while the game is in the play state.
- `Frame_Tick` out 1: one-cycle pulse per frame.
- `Move_Valid_1`, `Move_Valid_2` out 1: one-cycle move command for player 1 / player 2.
- `Dir_1`, `Dir_2` out 2: direction: 00 down, 01 up, 10 left, 11 right.
- `Bomb_Req_1`, `Bomb_Req_2` out 1: one-cycle bomb-placement request.

## Operation
Key map (HID usage codes):
- Player 1: W 0x1A up, S 0x16 down, A 0x04 left, D 0x07 right, Space 0x2C bomb.
- Player 2: Up 0x52, Down 0x51, Left 0x50, Right 0x4F, Enter 0x28 bomb.

Decoding:
- `Keycode` is registered once (`kc_q`).
- Each slot is decoded to per-player held flags: dir_held, dir, bomb_held.
- If both slots carry a direction for the same player, slot 0 wins.
- Codes not in the map are ignored.

Frame tick:
- `Frame_Clk` passes through a 2-flop synchroniser, then a falling-edge detector.
- `Frame_Tick` is high for one cycle per detected falling edge.

Per-player state (evaluated only in a `Frame_Tick` cycle):
- IDLE, no direction held: stay in IDLE. No move.
- IDLE → HELD, direction held: pulse move with the decoded dir. Load rpt_cnt = `MOVE_PERIOD`−1.
- HELD, same direction still held:
  - rpt_cnt = 0: pulse move and reload `MOVE_PERIOD`−1.
  - otherwise: decrement rpt_cnt.
- HELD, different direction held: treat as a new press. Pulse immediately with the new dir and reload.
- HELD, no direction held: go to IDLE.

Bomb:
- `Bomb_Req_x` pulses on a tick where bomb_held = 1 and the bomb_held value sampled at the previous tick = 0.
- Holding the bomb key never re-fires.
- Bomb and move may pulse in the same cycle.

Direction output:
- `Dir_x` updates in the same cycle as its `Move_Valid_x` pulse and holds until the next pulse.

`Game_Enable` = 0:
- Both players forced to IDLE; rpt_cnt = 0; previous-bomb flags = 1.
- This stops a key already held when play starts from firing a bomb.
- `Frame_Tick` keeps running; `Move_Valid`/`Bomb_Req` stay 0.

Width rules:
- rpt_cnt is 4 bits.
- `MOVE_PERIOD` = 1 gives a move every frame.

## Timing
- Reset (async assert, sync-safe release):
  - all outputs 0, `Dir_x` = 00;
  - synchroniser flops 1 (`VS` idle high), so no spurious tick after reset;
  - FSMs IDLE, rpt_cnt 0, previous-bomb flags 1.
- Latency:
  - `Frame_Clk` falling edge → `Frame_Tick` high: 3 `Clk` cycles (2 sync + edge register).
  - `Frame_Tick` → `Move_Valid`/`Bomb_Req`: 1 cycle (registered).
- `Keycode` → decision: the value in `kc_q` during the `Frame_Tick` cycle is used. `Keycode` must be stable for ≥2 cycles before the tick to take effect on that tick.
- Keycode changes between ticks are not observed; only the tick sample counts.
- Reset asserted mid-frame clears everything immediately. The first tick after release is a normal tick.

## Test plan
1. Reset with `Frame_Clk` = 1, release, no keys, 5 frames → `Frame_Tick` ×5, 3 cycles after each falling edge. No `Move_Valid`/`Bomb_Req`. `Dir` = 00.
2. `Game_Enable` = 1, `Keycode` = 0x001A held 9 frames, `MOVE_PERIOD` = 4 → `Move_Valid_1` on frames 1, 5, 9; `Dir_1` = 01 each time. Player 2 silent.
3. `Keycode` = 0x0007 for 2 frames, then 0x0004 → right pulse on frame 1; left pulse with `Dir_1` = 10 on frame 3 (immediate on direction change, no wait).
4. `Keycode` = 0x2C52 (bomb P1 + up P2) held 6 frames → `Bomb_Req_1` once on frame 1. `Move_Valid_2` with `Dir_2` = 01 on frames 1 and 5.
5. `Keycode` = 0x0428 held while `Game_Enable` = 0 for 3 frames, then enable → no `Bomb_Req_2` ever. `Move_Valid_1` `Dir_1` = 10 on the first enabled frame. Release and re-press 0x28 → one `Bomb_Req_2`.
6. `Keycode` = 0x1A16 (both P1 dirs) → `Dir_1` = 00 (slot 0 wins). Assert `Reset_n` = 0 mid-frame → all outputs 0 asynchronously. Release → no tick until the next real falling edge.
